// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO pull-style read port and the valid/ready output stream.
// The master side is the reader adapter; the slave side is the surrounding
// environment (FIFO read port plus downstream consumer).
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    // FIFO read port
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_req;

    // Output stream
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_req,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_req,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port (pop request, data one cycle after the pop) into a
// valid/ready stream. A two-entry buffer (head + skid) covers the one-cycle
// read latency so that a continuously ready consumer sees one word per clock.
// Pops are only issued when the buffer is guaranteed to have room for the
// word once it arrives, so captured words can never overflow the buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fifo_stream_reader_if.master   bus,
    output logic [COUNT_WIDTH-1:0] word_count
);

    logic [1:0]            occ;          // buffered words, 0..2
    logic [1:0]            occ_after;    // occupancy after this cycle's transfer
    logic [1:0]            occ_next;
    logic                  inflight;     // fifo_data carries a popped word this cycle
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] head_next;
    logic [DATA_WIDTH-1:0] skid;
    logic [DATA_WIDTH-1:0] skid_next;
    logic                  valid;
    logic                  xfer;
    logic                  pop;
    logic [2:0]            committed;    // words held or arriving once this transfer retires

    assign valid         = (occ != 2'd0);
    assign xfer          = valid && bus.out_ready;
    assign bus.out_valid = valid;
    assign bus.out_data  = head;

    // A pop is allowed only if the buffer can still absorb the returning word
    // after accounting for the word already in flight and this cycle's transfer.
    assign committed    = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
    assign bus.fifo_req = reset_n && !bus.fifo_empty && (committed < 3'd2);
    assign pop          = bus.fifo_req && !bus.fifo_empty;

    // Next buffer contents: shift skid into head on a transfer, then place the
    // captured word in the lowest free slot.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        head_next = head;
        skid_next = skid;
        occ_after = occ - {1'b0, xfer};
        occ_next  = occ_after;

        if (xfer && (occ == 2'd2)) begin
            head_next = skid;
        end

        if (inflight) begin
            if (occ_after == 2'd0) begin
                head_next = bus.fifo_data;
            end else begin
                skid_next = bus.fifo_data;
            end
            occ_next = occ_after + 2'd1;
        end
    end

    // Control state, head word and delivered-word counter.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            occ        <= 2'd0;
            inflight   <= 1'b0;
            head       <= '0;
            word_count <= '0;
        end else begin
            occ      <= occ_next;
            inflight <= pop;
            head     <= head_next;
            if (xfer) begin
                word_count <= word_count + COUNT_WIDTH'(1);
            end
        end
    end

    // Skid data storage.
    always_ff @(posedge clk) begin
        // NOTE: the skid word is never read unless occ says it was written, so
        // it carries no reset; only the occupancy that qualifies it is reset.
        skid <= skid_next;
    end

endmodule
